// File: rtl/async_fifo_pkg.sv
// Shared defaults for the async_fifo block: data width and pointer/count width.
package async_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH       = 8;
    localparam int DEFAULT_FIFO_DEPTH_WIDTH = 5;

endpackage

// File: rtl/async_fifo_mem.sv
// Storage array for async_fifo: one synchronous write port and one asynchronous read port.
import async_fifo_pkg::*;

module async_fifo_mem #(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_FIFO_DEPTH_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Contents are deliberately not reset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/async_fifo.sv
// Single-clock FIFO holding 2^W-1 words with registered flags and occupancy counts.
// Define ASYNC_FIFO_FWFT_EN for first-word-fall-through output; default is one-cycle read latency.
import async_fifo_pkg::*;

module async_fifo #(
    parameter int DATA_WIDTH       = DEFAULT_DATA_WIDTH,
    parameter int FIFO_DEPTH_WIDTH = DEFAULT_FIFO_DEPTH_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        write,
    input  logic                        read,
    input  logic [DATA_WIDTH-1:0]       data_write,
    output logic [DATA_WIDTH-1:0]       data_read,
    output logic                        full,
    output logic                        empty,
    output logic [FIFO_DEPTH_WIDTH-1:0] data_count_w,
    output logic [FIFO_DEPTH_WIDTH-1:0] data_count_r
);

    localparam logic [FIFO_DEPTH_WIDTH-1:0] MAX_COUNT = '1;
    localparam logic [FIFO_DEPTH_WIDTH-1:0] ZERO      = '0;

    logic [FIFO_DEPTH_WIDTH-1:0] wptr;
    logic [FIFO_DEPTH_WIDTH-1:0] rptr;
    logic [FIFO_DEPTH_WIDTH-1:0] count;
    logic [FIFO_DEPTH_WIDTH-1:0] count_next;
    logic [FIFO_DEPTH_WIDTH-1:0] rd_step;
    logic [FIFO_DEPTH_WIDTH-1:0] wr_step;
    logic [FIFO_DEPTH_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0]       mem_rdata;
    logic                        wr_en;
    logic                        rd_en;

    assign wr_en   = write & ~full;
    assign rd_en   = read & ~empty;
    assign rd_step = {{(FIFO_DEPTH_WIDTH-1){1'b0}}, rd_en};
    assign wr_step = {{(FIFO_DEPTH_WIDTH-1){1'b0}}, wr_en};

    always_comb begin
        count_next = count + wr_step - rd_step;
    end

`ifdef ASYNC_FIFO_FWFT_EN
    // Look one word ahead so the head is already registered when a read advances it.
    assign raddr = rptr + rd_step;
`else
    assign raddr = rptr;
`endif

    async_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (FIFO_DEPTH_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wptr),
        .wdata (data_write),
        .raddr (raddr),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            wptr  <= wptr + wr_step;
            rptr  <= rptr + rd_step;
            count <= count_next;
            full  <= (count_next == MAX_COUNT);
            empty <= (count_next == ZERO);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_read <= '0;
        end else begin
`ifdef ASYNC_FIFO_FWFT_EN
            // When the only remaining word is the one arriving now, bypass it from the input.
            if ((count - rd_step) != ZERO) begin
                data_read <= mem_rdata;
            end else if (wr_en) begin
                data_read <= data_write;
            end
`else
            if (rd_en) begin
                data_read <= mem_rdata;
            end
`endif
        end
    end

    assign data_count_w = count;
    assign data_count_r = count;

endmodule

// File: tb/tb_async_fifo.sv
// Self-checking bench for async_fifo: a directed vector table followed by fill/drain,
// streaming, full-collision and reset sequences; expectations follow ASYNC_FIFO_FWFT_EN.
module tb_async_fifo;

`ifdef ASYNC_FIFO_FWFT_EN
    localparam bit FWFT = 1'b1;
`else
    localparam bit FWFT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       write;
    logic       read;
    logic [7:0] data_write;
    logic [7:0] data_read;
    logic       full;
    logic       empty;
    logic [4:0] data_count_w;
    logic [4:0] data_count_r;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       rst;
        logic       write;
        logic       read;
        logic [7:0] din;
        logic       exp_empty;
        logic       exp_full;
        int         exp_count;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs [9];

    always #5 clk = ~clk;

    async_fifo #(
        .DATA_WIDTH       (8),
        .FIFO_DEPTH_WIDTH (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .write        (write),
        .read         (read),
        .data_write   (data_write),
        .data_read    (data_read),
        .full         (full),
        .empty        (empty),
        .data_count_w (data_count_w),
        .data_count_r (data_count_r)
    );

    task automatic check_output(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_state(input string name, input bit exp_empty, input bit exp_full,
                               input int exp_count, input int exp_data);
        check_output({name, ".empty"}, int'(empty), int'(exp_empty));
        check_output({name, ".full"}, int'(full), int'(exp_full));
        check_output({name, ".count_w"}, int'(data_count_w), exp_count);
        check_output({name, ".count_r"}, int'(data_count_r), exp_count);
        check_output({name, ".data"}, int'(data_read), exp_data);
    endtask

    // Drive one clock edge worth of inputs, then return at the following falling edge.
    task automatic apply_stimulus(input bit r, input bit w, input bit rd, input logic [7:0] d);
        rst        = r;
        write      = w;
        read       = rd;
        data_write = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        write      = 1'b0;
        read       = 1'b0;
        data_write = 8'h00;

        //           rst wr rd din    emp full cnt data
        vecs[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1, FWFT ? 8'hA5 : 8'h00};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 2, FWFT ? 8'hA5 : 8'h00};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1, FWFT ? 8'h3C : 8'hA5};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1, FWFT ? 8'h77 : 8'h3C};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 0, 8'h77};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 0, 8'h77};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1, FWFT ? 8'h11 : 8'h77};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 0, 8'h00};

        for (int i = 0; i < 9; i++) begin
            apply_stimulus(vecs[i].rst, vecs[i].write, vecs[i].read, vecs[i].din);
            check_state($sformatf("vec%0d", i), vecs[i].exp_empty, vecs[i].exp_full,
                        vecs[i].exp_count, int'(vecs[i].exp_data));
        end

        // Fill past capacity: words 31..40 must be dropped.
        apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i <= 40; i++) begin
            apply_stimulus(1'b0, 1'b1, 1'b0, 8'(i));
            check_state($sformatf("fill%0d", i), 1'b0, i >= 30, (i >= 30) ? 31 : i + 1, 0);
        end

        // Drain past empty: data_read walks 0..30 and then holds 30.
        for (int i = 0; i <= 40; i++) begin
            apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00);
            check_state($sformatf("drain%0d", i), i >= 30, 1'b0, (i >= 30) ? 0 : 30 - i,
                        FWFT ? ((i >= 29) ? 30 : i + 1) : ((i >= 30) ? 30 : i));
        end

        // Streaming with read held high: occupancy never exceeds one word.
        apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k <= 50; k++) begin
            apply_stimulus(1'b0, 1'b1, 1'b1, 8'(k));
            check_state($sformatf("stream%0d", k), 1'b0, 1'b0, 1,
                        FWFT ? k : ((k == 0) ? 0 : k - 1));
        end
        apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00);
        check_state("stream_end", 1'b1, 1'b0, 0, 50);

        // Read and write together while full: only the read is accepted.
        apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 31; i++) begin
            apply_stimulus(1'b0, 1'b1, 1'b0, 8'(100 + i));
        end
        check_state("at_full", 1'b0, 1'b1, 31, FWFT ? 100 : 0);
        apply_stimulus(1'b0, 1'b1, 1'b1, 8'hFF);
        check_state("full_rw", 1'b0, 1'b0, 30, FWFT ? 101 : 100);
        for (int i = 0; i < 30; i++) begin
            apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00);
        end
        check_state("full_rw_drain", 1'b1, 1'b0, 0, 130);

        // Reset with stored words: none of them may come back afterwards.
        apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b0, 1'b1, 1'b0, 8'(200 + i));
        end
        check_state("pre_reset", 1'b0, 1'b0, 10, FWFT ? 200 : 0);
        apply_stimulus(1'b1, 1'b1, 1'b1, 8'h55);
        check_state("reset10", 1'b1, 1'b0, 0, 0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00);
        check_state("post_reset_read", 1'b1, 1'b0, 0, 0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 8'hEE);
        check_state("post_reset_wr", 1'b0, 1'b0, 1, FWFT ? 8'hEE : 0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00);
        check_state("post_reset_rd", 1'b1, 1'b0, 0, 8'hEE);

        apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/async_fifo.md
ASYNC_FIFO -- requirements
Module: async_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the data word width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH_WIDTH, default 5, giving the pointer/count width W; capacity is 2^W-1 words (31 at default).
REQ-003 SHALL have port clk, input, 1, the single clock for all logic, rising-edge active.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port write, input, 1, write request.
REQ-006 SHALL have port read, input, 1, read request.
REQ-007 SHALL have port data_write, input, DATA_WIDTH, write data.
REQ-008 SHALL have port data_read, output, DATA_WIDTH, read data.
REQ-009 SHALL have port full, output, 1, high when the FIFO holds 2^W-1 words.
REQ-010 SHALL have port empty, output, 1, high when the FIFO holds 0 words.
REQ-011 SHALL have port data_count_w, output, W, occupancy count for write-side flow control.
REQ-012 SHALL have port data_count_r, output, W, occupancy count for read-side flow control.

Function
REQ-013 SHALL accept a write on a clk edge where write=1 and full=0: store data_write, advance the write pointer modulo 2^W.
REQ-014 SHALL accept a read on a clk edge where read=1 and empty=0: advance the read pointer modulo 2^W.
REQ-015 SHALL ignore write while full=1, including when a read is accepted on the same edge; no storage, no pointer or count change.
REQ-016 SHALL ignore read while empty=1, including when a write is accepted on the same edge; data_read holds its value.
REQ-017 SHALL leave the occupancy unchanged when a read and a write are both accepted on one edge.
REQ-018 SHALL register full, empty, data_count_w and data_count_r so they reflect the accepted operations one edge after they occur.
REQ-019 SHALL make data_count_w and data_count_r both equal the exact occupancy, 0..2^W-1; they never wrap.
REQ-020 SHALL, in default mode, load data_read with the oldest word on the edge that accepts a read (one-cycle latency) and hold it otherwise.
REQ-021 SHALL output words in strict write order across pointer wrap-around.

Reset
REQ-022 SHALL, while rst=1 at a clk edge, clear both pointers, set data_count_w=data_count_r=0, empty=1, full=0 and data_read=0, overriding any read or write on that edge.
REQ-023 SHALL not require memory contents to be cleared; after reset, words written before reset are never returned.

Configuration
REQ-024 SHALL implement first-word-fall-through mode when macro ASYNC_FIFO_FWFT_EN is defined: data_read shows the oldest word whenever empty=0, and an accepted read advances to the next word.
REQ-025 SHALL, with ASYNC_FIFO_FWFT_EN undefined, behave as in REQ-020; flags, counts and acceptance rules are identical in both modes.

Structure
REQ-026 SHALL take the default DATA_WIDTH and FIFO_DEPTH_WIDTH constants from shared package async_fifo_pkg.
REQ-027 SHALL place storage in one sub-module, async_fifo_mem: 2^W x DATA_WIDTH, one synchronous write port and one read port.
REQ-028 SHALL keep pointer, count and flag logic in async_fifo.

Verification
REQ-029 SHALL cover this case: after reset, drive write=1 for 41 cycles with data 0..40 -> 0..30 stored, full=1 after the 31st write, both counts=31, data 31..40 dropped.
REQ-030 SHALL cover this case: from full, drive read=1 for 41 cycles -> data_read returns 0..30 in order, empty=1 after the 31st read, counts=0, data_read holds 30 afterwards.
REQ-031 SHALL cover this case: hold read=1 while writing 0..50 on consecutive cycles -> every word is read out in order, no underflow, counts never exceed 1.
REQ-032 SHALL cover this case: at full, assert read=1 and write=1 together -> read accepted, write dropped, count becomes 30, full=0.
REQ-033 SHALL cover this case: assert rst=1 with 10 words stored -> next edge empty=1, counts=0, data_read=0, old words never reappear.
REQ-034 SHALL cover this case: rerun REQ-029..REQ-031 with ASYNC_FIFO_FWFT_EN defined -> data_read shows word 0 one edge after the first write.
